// File: rtl/sensor_debounce_pkg.sv
// Shared defaults and widths for the barrier-sensor conditioning block.
package sensor_debounce_pkg;

  localparam int unsigned TP_DEB_CYCLES  = 16;
  localparam int unsigned TP_SYNC_STAGES = 2;
  localparam int unsigned GLITCH_W       = 8;

endpackage

// File: rtl/debounce_ch.sv
// One sensor channel: synchroniser, stability counter, debounced level and edge pulses.
// Optional per-channel aborted-transition counter under SENSOR_GLITCH_CNT_EN.
module debounce_ch
  import sensor_debounce_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = TP_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = TP_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw,
  output logic                level,
  output logic                rise,
  output logic                fall
`ifdef SENSOR_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   level_d, rise_d, fall_d;

  assign s = sync[SYNC_STAGES-1];

  // Next-state: a new level is accepted only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s != level) begin
      if (cnt == CNT_LAST) begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

`ifdef SENSOR_GLITCH_CNT_EN
  logic glitch_ev;

  // A partial count abandoned because s fell back to the current level.
  assign glitch_ev = (s == level) && (cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt <= '0;
    end else if (glitch_ev && (glitch_cnt != {GLITCH_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: rtl/sensor_debounce.sv
// Synchronises and debounces the outer (b1) and inner (b2) barrier sensors.
// Define SENSOR_GLITCH_CNT_EN to expose per-channel saturating glitch counters.
module sensor_debounce
  import sensor_debounce_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = TP_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = TP_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                b1_raw,
  input  logic                b2_raw,
  output logic                b1,
  output logic                b2,
  output logic                b1_rise,
  output logic                b1_fall,
  output logic                b2_rise,
  output logic                b2_fall
`ifdef SENSOR_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt1,
  output logic [GLITCH_W-1:0] glitch_cnt2
`endif
);

  debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .raw       (b1_raw),
    .level     (b1),
    .rise      (b1_rise),
    .fall      (b1_fall)
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt1)
`endif
  );

  debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch2 (
    .clk       (clk),
    .reset     (reset),
    .raw       (b2_raw),
    .level     (b2),
    .rise      (b2_rise),
    .fall      (b2_fall)
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt2)
`endif
  );

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce with DEB_CYCLES=4, SYNC_STAGES=2 (level moves at edge 6).
module tb_sensor_debounce;

  logic clk = 1'b0;
  logic reset;
  logic b1_raw, b2_raw;
  logic b1, b2, b1_rise, b1_fall, b2_rise, b2_fall;
`ifdef SENSOR_GLITCH_CNT_EN
  logic [7:0] glitch_cnt1, glitch_cnt2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic h1 [0:63];
  logic h2 [0:63];

  always #5 clk = ~clk;

  sensor_debounce #(
    .DEB_CYCLES (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b1_raw     (b1_raw),
    .b2_raw     (b2_raw),
    .b1         (b1),
    .b2         (b2),
    .b1_rise    (b1_rise),
    .b1_fall    (b1_fall),
    .b2_rise    (b2_rise),
    .b2_fall    (b2_fall)
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    .glitch_cnt1(glitch_cnt1),
    .glitch_cnt2(glitch_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch_b2(input int width);
    b2_raw = 1'b1;
    for (int i = 0; i < width; i++) begin
      tick(1);
      check("glitch_hold", {4'b0, b2, b2_rise, b2_fall, 1'b0}, 8'h00);
    end
    b2_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_tail", {4'b0, b2, b2_rise, b2_fall, 1'b0}, 8'h00);
    end
  endtask

  initial begin
    reset  = 1'b0;
    b1_raw = 1'b1;
    b2_raw = 1'b1;

    // Reset held with raw high, then release: both levels rise at edge 6.
    tick(3);
    check("rst_out", {2'b0, b1, b2, b1_rise, b1_fall, b2_rise, b2_fall}, 8'h00);
`ifdef SENSOR_GLITCH_CNT_EN
    check("rst_gc1", glitch_cnt1, 8'h00);
    check("rst_gc2", glitch_cnt2, 8'h00);
`endif
    reset = 1'b1;
    tick(5);
    check("rel_e5", {6'b0, b1, b1_rise}, 8'h00);
    tick(1);
    check("rel_e6", {4'b0, b1, b1_rise, b2, b2_rise}, 8'h0f);
    tick(1);
    check("rel_e7", {4'b0, b1, b1_rise, b2, b2_rise}, 8'h0a);

    b1_raw = 1'b0;
    b2_raw = 1'b0;
    tick(5);
    check("drop_e5", {4'b0, b1, b1_fall, b2, b2_fall}, 8'h0a);
    tick(1);
    check("drop_e6", {4'b0, b1, b1_fall, b2, b2_fall}, 8'h05);
    tick(1);
    check("drop_e7", {4'b0, b1, b1_fall, b2, b2_fall}, 8'h00);

    // b1 rise held 8 cycles then fall.
    b1_raw = 1'b1;
    tick(5);
    check("b1r_e5", {5'b0, b1, b1_rise, b1_fall}, 8'h00);
    tick(1);
    check("b1r_e6", {5'b0, b1, b1_rise, b1_fall}, 8'h06);
    tick(1);
    check("b1r_e7", {5'b0, b1, b1_rise, b1_fall}, 8'h04);
    tick(1);
    b1_raw = 1'b0;
    tick(5);
    check("b1f_e5", {5'b0, b1, b1_rise, b1_fall}, 8'h04);
    tick(1);
    check("b1f_e6", {5'b0, b1, b1_rise, b1_fall}, 8'h01);
    tick(1);
    check("b1f_e7", {5'b0, b1, b1_rise, b1_fall}, 8'h00);

    // Short glitches on b2 must be filtered.
    glitch_b2(1);
    glitch_b2(3);
`ifdef SENSOR_GLITCH_CNT_EN
    check("gc2_two", glitch_cnt2, 8'h02);
    check("gc1_zero", glitch_cnt1, 8'h00);
`endif

    // Entry sequence: outputs equal raw delayed so that raw before edge k appears after edge k+5.
    for (int t = 0; t < 64; t++) begin
      h1[t] = 1'b0;
      h2[t] = 1'b0;
    end
    for (int t = 1; t <= 46; t++) begin
      logic r1, r2, e1, e2, p1, p2;
      r1 = (t >= 1 && t <= 20);
      r2 = (t >= 11 && t <= 30);
      h1[t] = r1;
      h2[t] = r2;
      b1_raw = r1;
      b2_raw = r2;
      tick(1);
      e1 = (t - 5 >= 1) ? h1[t-5] : 1'b0;
      e2 = (t - 5 >= 1) ? h2[t-5] : 1'b0;
      p1 = (t - 6 >= 1) ? h1[t-6] : 1'b0;
      p2 = (t - 6 >= 1) ? h2[t-6] : 1'b0;
      check("entry_seq", {2'b0, b1, b2, b1_rise, b1_fall, b2_rise, b2_fall},
            {2'b0, e1, e2, e1 & ~p1, ~e1 & p1, e2 & ~p2, ~e2 & p2});
    end

    // Simultaneous rise on both channels.
    b1_raw = 1'b1;
    b2_raw = 1'b1;
    tick(5);
    check("sim_e5", {6'b0, b1_rise, b2_rise}, 8'h00);
    tick(1);
    check("sim_e6", {4'b0, b1, b2, b1_rise, b2_rise}, 8'h0f);
    b1_raw = 1'b0;
    tick(7);
    check("sim_b1_low", {6'b0, b1, b2}, 8'h01);

    // Reset asserted between edges while b1 is mid-count (cnt=2) and b2 is high.
    b1_raw = 1'b1;
    tick(4);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst", {2'b0, b1, b2, b1_rise, b1_fall, b2_rise, b2_fall}, 8'h00);
    b1_raw = 1'b0;
    b2_raw = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("post_rst", {2'b0, b1, b2, b1_rise, b1_fall, b2_rise, b2_fall}, 8'h00);
    end
`ifdef SENSOR_GLITCH_CNT_EN
    check("rst_gc2_clr", glitch_cnt2, 8'h00);

    // 300 one-cycle glitches on b1 saturate its counter.
    for (int i = 0; i < 300; i++) begin
      b1_raw = 1'b1;
      tick(1);
      b1_raw = 1'b0;
      tick(2);
    end
    tick(4);
    check("gc1_sat", glitch_cnt1, 8'hff);
    check("gc1_b1", {7'b0, b1}, 8'h00);
    check("gc1_gc2", glitch_cnt2, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
